// File: rtl/sample_stream_pkg.sv
// Shared definitions for the sample stream player: default widths and the
// playback FSM state encoding.
package sample_stream_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DIV_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PRESENT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/sample_stream_ram.sv
// Sample buffer: DATA_W x 2**ADDR_W, one write port, one synchronous read
// port. A read and a write to the same address in one cycle return old data.
module sample_stream_ram
    import sample_stream_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Read-before-write storage array with registered read data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data <= mem_q[rd_addr];
    end

endmodule

// File: rtl/sample_stream_player.sv
// Sample stream player: streams an address window of a loadable sample
// buffer over a valid/ready handshake, one-shot or looping, with a rate
// divider and abort. Optional build macro SAMPLE_STREAM_GAIN_SHIFT_EN adds a
// gain_shift input that arithmetically right-shifts every played sample.
module sample_stream_player
    import sample_stream_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DIV_W  = DEFAULT_DIV_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_loop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DIV_W-1:0]  rate_div,
`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
    input  logic [3:0]        gain_shift,
`endif
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              loop_q, loop_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;
    logic [DATA_W-1:0] rd_data;
    logic              stop_act;
    logic              resume;
`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
    logic [3:0]        gain_q, gain_d;

    // Sign-preserving attenuation of a buffer word.
    function automatic logic signed [DATA_W-1:0] gain_sample(
        input logic signed [DATA_W-1:0] d,
        input logic [3:0]               sh
    );
        return d >>> sh;
    endfunction
`endif

    // The RAM is addressed with the next address so that the word for the
    // current address is already registered during the FETCH cycle.
    sample_stream_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (addr_d),
        .rd_data (rd_data)
    );

    // Next-state, address, divider and output register logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        start_d     = start_q;
        end_d       = end_q;
        loop_d      = loop_q;
        div_d       = div_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        resume      = 1'b0;
`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
        gain_d      = gain_q;
`endif
        stop_act    = stop && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                out_valid_d = 1'b0;
                if (start && !stop_act) begin
                    start_d = start_addr;
                    end_d   = end_addr;
                    loop_d  = mode_loop;
                    div_d   = rate_div;
                    addr_d  = start_addr;
`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
                    gain_d  = gain_shift;
`endif
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
                out_data_d  = gain_sample($signed(rd_data), gain_q);
`else
                out_data_d  = rd_data;
`endif
                out_valid_d = 1'b1;
                state_d     = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (addr_q == end_q) begin
                        if (loop_q) begin
                            addr_d = start_q;
                            wrap_d = 1'b1;
                            resume = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        resume = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - DIV_W'(1);
                if (cnt_q <= DIV_W'(1)) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // After an accepted sample, either fetch immediately or idle for
        // div_q cycles first.
        if (resume) begin
            if (div_q == '0) begin
                state_d = ST_FETCH;
            end else begin
                state_d = ST_HOLD;
                cnt_d   = div_q;
            end
        end

        // Abort wins over everything; a handshake in this cycle still counts.
        if (stop_act) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
            wrap_d      = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            start_q     <= '0;
            end_q       <= '0;
            loop_q      <= 1'b0;
            div_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
            gain_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            end_q       <= end_d;
            loop_q      <= loop_d;
            div_q       <= div_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
            gain_q      <= gain_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_PRESENT) ||
                       (state_q == ST_HOLD);

endmodule

// File: tb/tb_sample_stream_player.sv
// Self-checking bench for sample_stream_player (default 16-bit x 32 entries).
module tb_sample_stream_player;

    localparam int DEPTH = 32;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        stop;
    logic        mode_loop;
    logic [4:0]  start_addr;
    logic [4:0]  end_addr;
    logic [7:0]  rate_div;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic        wrap;
`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
    logic [3:0]  gain_shift;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] ref_mem [DEPTH];

    // Observations gathered by the monitor
    int          cyc = 0;
    int          start_cyc = 0;
    logic [15:0] got_data [$];
    int          got_cyc [$];
    bit          got_stop [$];
    int          done_cyc [$];
    int          wrap_cyc [$];
    bit          prev_stall = 0;
    logic [15:0] prev_data = '0;

    sample_stream_player dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .mode_loop  (mode_loop),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rate_div   (rate_div),
`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
        .gain_shift (gain_shift),
`endif
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k-th address played from a window that may wrap past the top address.
    function automatic int exp_addr(input int s, input int e, input int k);
        int len;
        len = ((e - s + DEPTH) % DEPTH) + 1;
        return (s + (k % len)) % DEPTH;
    endfunction

    // Monitor on the falling edge: handshakes, pulses and stall stability.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (start && !busy) start_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            prev_stall = out_valid && !out_ready && !stop;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_cyc.push_back(cyc);
                got_stop.push_back(stop);
            end
            if (done) done_cyc.push_back(cyc);
            if (wrap) wrap_cyc.push_back(cyc);
        end else begin
            prev_stall = 0;
        end
    end

    task automatic clear_obs();
        got_data.delete();
        got_cyc.delete();
        got_stop.delete();
        done_cyc.delete();
        wrap_cyc.delete();
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Start a playback and drive it until the player goes idle; stop is
    // raised once max_acc samples have been accepted.
    task automatic play(input int s, input int e, input int lp, input int div,
                        input int rdy_pct, input int max_acc, input bit jit);
        bit fin;
        clear_obs();
        start_addr = 5'(s);
        end_addr   = 5'(e);
        mode_loop  = lp[0];
        rate_div   = 8'(div);
        start      = 1'b1;
        out_ready  = ($urandom_range(99) < rdy_pct);
        @(posedge clk); #1;
        start = 1'b0;
        fin = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!busy) begin
                fin = 1;
                break;
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            if (jit) begin
                start      = 1'($urandom);
                start_addr = 5'($urandom);
                end_addr   = 5'($urandom);
                mode_loop  = 1'($urandom);
                rate_div   = 8'($urandom_range(7));
            end
            if (got_data.size() >= max_acc) stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
        end
        start = 1'b0;
        if (!fin) check("play_timeout_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Compare the observations against the window rules.
    task automatic verify(input string tag, input int s, input int e, input int lp,
                          input int div, input bit full_rdy, input int min_n, input int exact_n);
        int n;
        int len;
        int wexp [$];
        n   = got_data.size();
        len = ((e - s + DEPTH) % DEPTH) + 1;
        if (exact_n >= 0)  check({tag, "_count"}, 32'(n), 32'(exact_n));
        else if (lp == 0)  check({tag, "_count"}, 32'(n), 32'(len));
        else               check({tag, "_count_min"}, 32'(n >= min_n), 32'd1);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(ref_mem[exp_addr(s, e, i)]));
        if (full_rdy && n > 0) begin
            check({tag, "_first_latency"}, 32'(got_cyc[0]), 32'(start_cyc + 2));
            for (int i = 1; i < n; i++)
                check($sformatf("%s_period%0d", tag, i), 32'(got_cyc[i] - got_cyc[i-1]), 32'(2 + div));
        end
        if (lp == 0 && exact_n < 0) begin
            check({tag, "_done_count"}, 32'(done_cyc.size()), 32'd1);
            if (done_cyc.size() >= 1 && n > 0)
                check({tag, "_done_cycle"}, 32'(done_cyc[0]), 32'(got_cyc[n-1] + 1));
        end else begin
            check({tag, "_no_done"}, 32'(done_cyc.size()), 32'd0);
        end
        for (int i = 0; i < n; i++)
            if (lp != 0 && exp_addr(s, e, i) == e && !got_stop[i]) wexp.push_back(got_cyc[i] + 1);
        check({tag, "_wrap_count"}, 32'(wrap_cyc.size()), 32'(wexp.size()));
        for (int i = 0; i < wexp.size() && i < wrap_cyc.size(); i++)
            check($sformatf("%s_wrap%0d", tag, i), 32'(wrap_cyc[i]), 32'(wexp[i]));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        bit seen;
        int s, e, d, r;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; mode_loop = 1'b0;
        start_addr = '0; end_addr = '0; rate_div = '0; out_ready = 1'b0;
`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
        gain_shift = 4'd0;
`endif
        #2 reset = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Buffer load: random table with the three fixed points
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0)       write_word(i, 16'h0003);
            else if (i == 16) write_word(i, 16'h0006);
            else if (i == 17) write_word(i, 16'hFFE0);
            else              write_word(i, 16'($urandom));
        end

        // Full one-shot, back-to-back
        play(0, 31, 0, 0, 100, 1000, 0);
        verify("oneshot_full", 0, 31, 0, 0, 1, 0, -1);

        // Loop through the top address
        play(30, 1, 1, 0, 100, 10, 0);
        verify("loop_wrap", 30, 1, 1, 0, 1, 10, -1);

        // Rate divider 3 -> 5-cycle period
        play(8, 15, 0, 3, 100, 1000, 0);
        verify("rate3", 8, 15, 0, 3, 1, 0, -1);

        // Abort in HOLD right after the second sample
        play(4, 9, 1, 3, 100, 2, 0);
        verify("stop_hold", 4, 9, 1, 3, 1, 2, 2);

        // Single-sample window
        play(7, 7, 0, 1, 100, 1000, 0);
        verify("single", 7, 7, 0, 1, 1, 0, -1);

        // Backpressure: ready low for 7 cycles on address 5
        clear_obs();
        out_ready = 1'b0; start_addr = 5'd5; end_addr = 5'd7;
        mode_loop = 1'b0; rate_div = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        for (int c = 0; c < 7; c++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'(ref_mem[5]));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (!busy) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        check("bp_finished", 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        verify("backpressure", 5, 7, 0, 0, 0, 0, -1);

        // Randomised one-shot windows with jittered inputs while busy
        for (int k = 0; k < 4; k++) begin
            s = int'($urandom_range(31));
            e = int'($urandom_range(31));
            d = int'($urandom_range(3));
            r = ($urandom_range(1) == 1) ? 100 : 60;
            play(s, e, 0, d, r, 1000, 1);
            verify($sformatf("rand_os%0d", k), s, e, 0, d, r == 100, 0, -1);
        end

        // Randomised loop windows, aborted after a random sample count
        for (int k = 0; k < 2; k++) begin
            s = int'($urandom_range(31));
            e = int'($urandom_range(31));
            d = int'($urandom_range(2));
            r = int'($urandom_range(12, 5));
            play(s, e, 1, d, 70, r, 1);
            verify($sformatf("rand_loop%0d", k), s, e, 1, d, 0, r, -1);
        end

        // Asynchronous reset in the middle of PRESENT
        clear_obs();
        out_ready = 1'b0; start_addr = 5'd10; end_addr = 5'd12;
        mode_loop = 1'b0; rate_div = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        check("mid_rst_valid_seen", 32'(seen), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_wrap", 32'(wrap), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_no_done", 32'(done_cyc.size()), 32'd0);

        // Buffer survives reset
        play(20, 22, 0, 0, 100, 1000, 0);
        verify("after_reset", 20, 22, 0, 0, 1, 0, -1);

`ifdef SAMPLE_STREAM_GAIN_SHIFT_EN
        // Arithmetic shift by 4
        write_word(2, 16'hFF80);
        write_word(3, 16'h00FF);
        gain_shift = 4'd4;
        play(2, 3, 0, 0, 100, 1000, 0);
        gain_shift = 4'd0;
        check("gain_count", 32'(got_data.size()), 32'd2);
        if (got_data.size() >= 2) begin
            check("gain_neg", 32'(got_data[0]), 32'h0000FFF8);
            check("gain_pos", 32'(got_data[1]), 32'h0000000F);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
